// File: rtl/sid_voice_sched.sv
// sid_voice_sched: frame sequencer and mixer for N_SIDS SID cores sharing one
// voice pipeline and one filter pipeline. Each tick issues 3*N_SIDS voice
// requests, hands each SID's voice triple to the filter, and mixes the
// filter results into a saturated stereo frame.
// Optional feature macro: SID_SCHED_PAN_EN (adds the per-SID pan port).
module sid_voice_sched #(
    parameter int  N_SIDS    = 2,
    parameter int  VOICE_LAT = 1,
    localparam int SEL_W     = ($clog2(3 * N_SIDS) < 1) ? 1 : $clog2(3 * N_SIDS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    output logic                voice_req,
    output logic [SEL_W-1:0]    voice_sel,
    input  logic signed [21:0]  voice_res,
    output logic                filt_valid,
    input  logic                filt_ready,
    output logic [2:0]          filt_sid,
    output logic signed [21:0]  filt_v1,
    output logic signed [21:0]  filt_v2,
    output logic signed [21:0]  filt_v3,
    input  logic                filt_done,
    input  logic signed [19:0]  filt_res,
`ifdef SID_SCHED_PAN_EN
    input  logic [2*N_SIDS-1:0] pan,
`endif
    output logic [23:0]         audio_l,
    output logic [23:0]         audio_r,
    output logic                audio_valid,
    output logic                busy,
    output logic                overrun
);

    localparam int NV    = 3 * N_SIDS;
    localparam int ACC_W = 20 + $clog2(N_SIDS) + 1;
    localparam int CNT_W = $clog2(N_SIDS + 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(524287);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-524288);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUTPUT} state_t;

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic                    tag_vld_q [VOICE_LAT];
    logic                    tag_vld_d [VOICE_LAT];
    logic [SEL_W-1:0]        tag_sel_q [VOICE_LAT];
    logic [SEL_W-1:0]        tag_sel_d [VOICE_LAT];
    logic signed [21:0]      vbuf_q [NV];
    logic signed [21:0]      vbuf_d [NV];
    logic [N_SIDS-1:0]       rdy_q, rdy_d;
    logic                    filt_valid_q, filt_valid_d;
    logic [2:0]              filt_sid_q, filt_sid_d;
    logic                    outst_q, outst_d;
    logic [CNT_W-1:0]        done_cnt_q, done_cnt_d;
    logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [23:0]             audio_l_q, audio_l_d, audio_r_q, audio_r_d;
    logic                    audio_valid_q, audio_valid_d;
    logic                    overrun_q, overrun_d;
    logic [2*N_SIDS-1:0]     pan_eff;
    logic                    pick_found;
    logic [2:0]              pick_sid;

    // Clamp a wide accumulator into the signed 20-bit output range.
    function automatic logic signed [19:0] sat20(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX)      sat20 = 20'sh7FFFF;
        else if (a < SAT_MIN) sat20 = 20'sh80000;
        else                  sat20 = a[19:0];
    endfunction

`ifdef SID_SCHED_PAN_EN
    assign pan_eff = pan;
`else
    // Fixed routing: even SIDs left, odd SIDs right, a lone SID feeds both.
    always_comb begin
        pan_eff = '0;
        for (int s = 0; s < N_SIDS; s++) begin
            if (N_SIDS == 1) begin
                pan_eff[2*s]   = 1'b1;
                pan_eff[2*s+1] = 1'b1;
            end else if ((s % 2) == 0) begin
                pan_eff[2*s] = 1'b1;
            end else begin
                pan_eff[2*s+1] = 1'b1;
            end
        end
    end
`endif

    // Lowest-index SID whose voice triple is complete.
    always_comb begin
        pick_found = 1'b0;
        pick_sid   = 3'd0;
        for (int s = N_SIDS - 1; s >= 0; s--) begin
            if (rdy_q[s]) begin
                pick_found = 1'b1;
                pick_sid   = 3'(s);
            end
        end
    end

    // Present the buffered triple of the SID currently offered to the filter.
    always_comb begin
        filt_v1 = '0;
        filt_v2 = '0;
        filt_v3 = '0;
        for (int s = 0; s < N_SIDS; s++) begin
            if (filt_sid_q == 3'(s)) begin
                filt_v1 = vbuf_q[3*s];
                filt_v2 = vbuf_q[3*s+1];
                filt_v3 = vbuf_q[3*s+2];
            end
        end
    end

    // Tag pipeline mirrors the voice pipeline so each result lands in its slot.
    always_comb begin
        tag_vld_d[0] = (state_q == S_ISSUE);
        tag_sel_d[0] = issue_cnt_q;
        for (int i = 1; i < VOICE_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_sel_d[i] = tag_sel_q[i-1];
        end
    end

    // Frame FSM, voice capture, filter handshake and mixing.
    always_comb begin
        state_d       = state_q;
        issue_cnt_d   = issue_cnt_q;
        rdy_d         = rdy_q;
        vbuf_d        = vbuf_q;
        filt_valid_d  = filt_valid_q;
        filt_sid_d    = filt_sid_q;
        outst_d       = outst_q;
        done_cnt_d    = done_cnt_q;
        acc_l_d       = acc_l_q;
        acc_r_d       = acc_r_q;
        audio_l_d     = audio_l_q;
        audio_r_d     = audio_r_q;
        audio_valid_d = 1'b0;
        overrun_d     = overrun_q;

        if (tag_vld_q[VOICE_LAT-1]) begin
            for (int i = 0; i < NV; i++)
                if (tag_sel_q[VOICE_LAT-1] == SEL_W'(i)) vbuf_d[i] = voice_res;
            for (int s = 0; s < N_SIDS; s++)
                if (tag_sel_q[VOICE_LAT-1] == SEL_W'(3*s+2)) rdy_d[s] = 1'b1;
        end

        // A stray done with nothing outstanding is ignored entirely.
        if (filt_done && outst_q) begin
            outst_d    = 1'b0;
            done_cnt_d = done_cnt_q + 1'b1;
            for (int s = 0; s < N_SIDS; s++) begin
                if (filt_sid_q == 3'(s)) begin
                    if (pan_eff[2*s])   acc_l_d = acc_l_q + ACC_W'(filt_res);
                    if (pan_eff[2*s+1]) acc_r_d = acc_r_q + ACC_W'(filt_res);
                end
            end
        end

        if (filt_valid_q) begin
            if (filt_ready) begin
                filt_valid_d = 1'b0;
                outst_d      = 1'b1;
                for (int s = 0; s < N_SIDS; s++)
                    if (filt_sid_q == 3'(s)) rdy_d[s] = 1'b0;
            end
        end else if ((state_q == S_ISSUE || state_q == S_DRAIN) &&
                     (!outst_q || filt_done) && pick_found) begin
            filt_valid_d = 1'b1;
            filt_sid_d   = pick_sid;
        end

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d     = S_ISSUE;
                    issue_cnt_d = '0;
                    done_cnt_d  = '0;
                    acc_l_d     = '0;
                    acc_r_d     = '0;
                end
            end
            S_ISSUE: begin
                if (tick) overrun_d = 1'b1;
                if (issue_cnt_q == SEL_W'(NV - 1)) begin
                    issue_cnt_d = '0;
                    state_d     = S_DRAIN;
                end else begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (tick) overrun_d = 1'b1;
                if (done_cnt_q == CNT_W'(N_SIDS)) begin
                    state_d       = S_OUTPUT;
                    audio_l_d     = {sat20(acc_l_q), 4'b0};
                    audio_r_d     = {sat20(acc_r_q), 4'b0};
                    audio_valid_d = 1'b1;
                end
            end
            S_OUTPUT: begin
                if (tick) overrun_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            issue_cnt_q   <= '0;
            for (int i = 0; i < VOICE_LAT; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_sel_q[i] <= '0;
            end
            for (int i = 0; i < NV; i++) vbuf_q[i] <= '0;
            rdy_q         <= '0;
            filt_valid_q  <= 1'b0;
            filt_sid_q    <= '0;
            outst_q       <= 1'b0;
            done_cnt_q    <= '0;
            acc_l_q       <= '0;
            acc_r_q       <= '0;
            audio_l_q     <= '0;
            audio_r_q     <= '0;
            audio_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_cnt_q   <= issue_cnt_d;
            tag_vld_q     <= tag_vld_d;
            tag_sel_q     <= tag_sel_d;
            vbuf_q        <= vbuf_d;
            rdy_q         <= rdy_d;
            filt_valid_q  <= filt_valid_d;
            filt_sid_q    <= filt_sid_d;
            outst_q       <= outst_d;
            done_cnt_q    <= done_cnt_d;
            acc_l_q       <= acc_l_d;
            acc_r_q       <= acc_r_d;
            audio_l_q     <= audio_l_d;
            audio_r_q     <= audio_r_d;
            audio_valid_q <= audio_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign voice_req   = (state_q == S_ISSUE);
    assign voice_sel   = issue_cnt_q;
    assign filt_valid  = filt_valid_q;
    assign filt_sid    = filt_sid_q;
    assign audio_l     = audio_l_q;
    assign audio_r     = audio_r_q;
    assign audio_valid = audio_valid_q;
    assign busy        = (state_q != S_IDLE);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_sid_voice_sched.sv
// Bench for sid_voice_sched: a two-SID instance (latency 1) for sequencing,
// stall, overrun and reset-abort, and a four-SID instance (latency 2) for
// saturation of the mixed output.
module tb_sid_voice_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   tests = 0;
    int   fails = 0;

    // Two-SID instance
    logic        tick2, req2, fv2, fr2, av2, busy2, ovr2;
    logic        fd2 = 1'b0;
    logic [2:0]  sel2, fsid2;
    logic [21:0] vres2 = '0;
    logic [21:0] v1_2, v2_2, v3_2;
    logic [19:0] fres2 = '0;
    logic [23:0] al2, ar2;
    // Four-SID instance
    logic        tick4, req4, fv4, fr4, av4, busy4, ovr4;
    logic        fd4 = 1'b0;
    logic [3:0]  sel4;
    logic [2:0]  fsid4;
    logic [21:0] vp4 = '0, vres4 = '0;
    logic [21:0] v1_4, v2_4, v3_4;
    logic [19:0] fres4 = '0;
    logic [23:0] al4, ar4;

    sid_voice_sched #(.N_SIDS(2), .VOICE_LAT(1)) dut2 (
        .clk(clk), .rst(rst), .tick(tick2), .voice_req(req2), .voice_sel(sel2),
        .voice_res(vres2), .filt_valid(fv2), .filt_ready(fr2), .filt_sid(fsid2),
        .filt_v1(v1_2), .filt_v2(v2_2), .filt_v3(v3_2), .filt_done(fd2),
        .filt_res(fres2),
`ifdef SID_SCHED_PAN_EN
        .pan(4'b1001),
`endif
        .audio_l(al2), .audio_r(ar2), .audio_valid(av2), .busy(busy2), .overrun(ovr2)
    );

    sid_voice_sched #(.N_SIDS(4), .VOICE_LAT(2)) dut4 (
        .clk(clk), .rst(rst), .tick(tick4), .voice_req(req4), .voice_sel(sel4),
        .voice_res(vres4), .filt_valid(fv4), .filt_ready(fr4), .filt_sid(fsid4),
        .filt_v1(v1_4), .filt_v2(v2_4), .filt_v3(v3_4), .filt_done(fd4),
        .filt_res(fres4),
`ifdef SID_SCHED_PAN_EN
        .pan(8'hFF),
`endif
        .audio_l(al4), .audio_r(ar4), .audio_valid(av4), .busy(busy4), .overrun(ovr4)
    );

    // Voice pipeline models: result = 1000 * voice index after VOICE_LAT cycles.
    always @(posedge clk) begin
        vres2 <= req2 ? 22'(1000 * int'(sel2)) : 22'd0;
        vp4   <= req4 ? 22'(1000 * int'(sel4)) : 22'd0;
        vres4 <= vp4;
    end

    // Filter models: answer 8 cycles after accepting a triple.
    int         fval2 [2];
    int         fval4;
    logic [2:0] fsid_m2 = '0;
    int         fcnt2 = 0, fcnt4 = 0;
    always @(posedge clk) begin
        fd2 <= 1'b0;
        fd4 <= 1'b0;
        if (fcnt2 > 0) begin
            fcnt2 <= fcnt2 - 1;
            if (fcnt2 == 1) begin
                fd2   <= 1'b1;
                fres2 <= 20'(fval2[fsid_m2[0]]);
            end
        end
        if (fv2 && fr2) begin
            fcnt2   <= 8;
            fsid_m2 <= fsid2;
        end
        if (fcnt4 > 0) begin
            fcnt4 <= fcnt4 - 1;
            if (fcnt4 == 1) begin
                fd4   <= 1'b1;
                fres4 <= 20'(fval4);
            end
        end
        if (fv4 && fr4) fcnt4 <= 8;
    end

    // Scoreboards
    typedef struct {int sid; int v1; int v2; int v3;} trip_t;
    typedef struct {logic [23:0] l; logic [23:0] r;} aud_t;
    int    q_sel2 [$];
    trip_t q_trip2 [$];
    aud_t  q_aud2 [$];
    aud_t  q_aud4 [$];
    int    apulses2 = 0, apulses4 = 0;
    logic  chk_filt2 = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (req2) begin
            chk("voice_sel2_expected", 64'(q_sel2.size() != 0), 64'd1);
            if (q_sel2.size() != 0) chk("voice_sel2", 64'(sel2), 64'(q_sel2.pop_front()));
        end
        if (fv2 && fr2 && chk_filt2) begin
            chk("filt2_expected", 64'(q_trip2.size() != 0), 64'd1);
            if (q_trip2.size() != 0) begin
                trip_t t;
                t = q_trip2.pop_front();
                chk("filt_sid2", 64'(fsid2), 64'(3'(t.sid)));
                chk("filt_v1_2", 64'(v1_2), 64'(22'(t.v1)));
                chk("filt_v2_2", 64'(v2_2), 64'(22'(t.v2)));
                chk("filt_v3_2", 64'(v3_2), 64'(22'(t.v3)));
            end
        end
        if (av2) begin
            apulses2++;
            chk("audio2_expected", 64'(q_aud2.size() != 0), 64'd1);
            if (q_aud2.size() != 0) begin
                aud_t a;
                a = q_aud2.pop_front();
                chk("audio_l2", 64'(al2), 64'(a.l));
                chk("audio_r2", 64'(ar2), 64'(a.r));
            end
        end
        if (av4) begin
            apulses4++;
            chk("audio4_expected", 64'(q_aud4.size() != 0), 64'd1);
            if (q_aud4.size() != 0) begin
                aud_t a;
                a = q_aud4.pop_front();
                chk("audio_l4", 64'(al4), 64'(a.l));
                chk("audio_r4", 64'(ar4), 64'(a.r));
            end
        end
    end

    task automatic push_frame2(input int r0, input int r1, input logic do_audio);
        aud_t a;
        for (int i = 0; i < 6; i++) q_sel2.push_back(i);
        q_trip2.push_back('{0, 0, 1000, 2000});
        q_trip2.push_back('{1, 3000, 4000, 5000});
        fval2[0] = r0;
        fval2[1] = r1;
        a.l = 24'(r0 * 16);
        a.r = 24'(r1 * 16);
        if (do_audio) q_aud2.push_back(a);
    endtask

    task automatic pulse_tick2();
        @(posedge clk); #1 tick2 = 1'b1;
        @(posedge clk); #1 tick2 = 1'b0;
    endtask

    task automatic pulse_tick4();
        @(posedge clk); #1 tick4 = 1'b1;
        @(posedge clk); #1 tick4 = 1'b0;
    endtask

    task automatic wait_idle2(input string tag);
        int n = 0;
        while (busy2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(busy2), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle4(input string tag);
        int n = 0;
        while (busy4 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(busy4), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        int changes;
        aud_t a4;
        rst   = 1'b1;
        tick2 = 1'b0;
        tick4 = 1'b0;
        fr2   = 1'b1;
        fr4   = 1'b1;
        fval2[0] = 100;
        fval2[1] = 200;
        fval4 = 524287;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_audio_l", 64'(al2), 64'd0);
        chk("rst_audio_r", 64'(ar2), 64'd0);
        chk("rst_audio_valid", 64'(av2), 64'd0);
        chk("rst_busy", 64'(busy2), 64'd0);
        chk("rst_overrun", 64'(ovr2), 64'd0);
        chk("rst_voice_req", 64'(req2), 64'd0);
        chk("rst_filt_valid", 64'(fv2), 64'd0);
        chk("rst_busy4", 64'(busy4), 64'd0);

        // Basic frame: sid0 -> left 100, sid1 -> right 200
        push_frame2(100, 200, 1'b1);
        pulse_tick2();
        @(negedge clk);
        chk("req_after_tick", 64'(req2), 64'd1);
        chk("busy_after_tick", 64'(busy2), 64'd1);
        wait_idle2("frame1_done");
        chk("frame1_pulses", 64'(apulses2), 64'd1);
        chk("frame1_hold_l", 64'(al2), 64'(24'(1600)));

        // Filter stalls for 20 cycles after the first valid
        fr2 = 1'b0;
        push_frame2(-300, 7, 1'b1);
        pulse_tick2();
        n = 0;
        while (!fv2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid_seen", 64'(fv2), 64'd1);
        changes = 0;
        for (int i = 0; i < 20; i++) begin
            if (fv2 !== 1'b1 || fsid2 !== 3'd0 || v1_2 !== 22'd0 ||
                v2_2 !== 22'd1000 || v3_2 !== 22'd2000) changes++;
            @(negedge clk);
        end
        chk("stall_stable", 64'(changes), 64'd0);
        @(posedge clk); #1 fr2 = 1'b1;
        wait_idle2("frame2_done");
        chk("frame2_pulses", 64'(apulses2), 64'd2);

        // Second tick 5 cycles into a frame is flagged and ignored
        push_frame2(100, 200, 1'b1);
        pulse_tick2();
        repeat (4) @(posedge clk);
        #1 tick2 = 1'b1;
        @(posedge clk); #1 tick2 = 1'b0;
        @(negedge clk);
        chk("overrun_set", 64'(ovr2), 64'd1);
        wait_idle2("frame3_done");
        repeat (10) @(negedge clk);
        chk("overrun_no_extra_frame", 64'(busy2), 64'd0);
        chk("frame3_pulses", 64'(apulses2), 64'd3);
        chk("overrun_sticky", 64'(ovr2), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_clears_overrun", 64'(ovr2), 64'd0);
        chk("rst_clears_audio", 64'(al2), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // A normal frame so the outputs are nonzero before the abort
        push_frame2(100, 200, 1'b1);
        pulse_tick2();
        wait_idle2("frame4_done");
        chk("frame4_pulses", 64'(apulses2), 64'd4);

        // Reset during DRAIN aborts the frame
        chk_filt2 = 1'b0;
        push_frame2(100, 200, 1'b0);
        pulse_tick2();
        repeat (10) @(negedge clk);
        chk("abort_in_frame", 64'(busy2), 64'd1);
        chk("abort_req_done", 64'(req2), 64'd0);
        #1 rst = 1'b1;
        #1;
        chk("abort_audio_l", 64'(al2), 64'd0);
        chk("abort_audio_r", 64'(ar2), 64'd0);
        chk("abort_busy", 64'(busy2), 64'd0);
        chk("abort_filt_valid", 64'(fv2), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("abort_no_audio", 64'(apulses2), 64'd4);
        q_trip2.delete();
        chk_filt2 = 1'b1;

        // Clean frame after the abort
        push_frame2(-5, 9, 1'b1);
        pulse_tick2();
        wait_idle2("frame6_done");
        chk("frame6_pulses", 64'(apulses2), 64'd5);

        // Four SIDs, positive saturation then negative saturation
        fval4 = 524287;
        a4.l = 24'h7FFFF0;
        a4.r = 24'h7FFFF0;
        q_aud4.push_back(a4);
        pulse_tick4();
        wait_idle4("sat_pos_done");
        fval4 = -524288;
        a4.l = 24'h800000;
        a4.r = 24'h800000;
        q_aud4.push_back(a4);
        pulse_tick4();
        wait_idle4("sat_neg_done");
        chk("sat_pulses", 64'(apulses4), 64'd2);

        chk("sel2_queue_empty", 64'(q_sel2.size()), 64'd0);
        chk("trip2_queue_empty", 64'(q_trip2.size()), 64'd0);
        chk("aud2_queue_empty", 64'(q_aud2.size()), 64'd0);
        chk("aud4_queue_empty", 64'(q_aud4.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
